// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-logic blocks.
// Holds the frame scheduler state encoding and the frame counter width.
package pong_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } sched_state_t;

    // Index width that stays legal (at least one bit) when the count is 1.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unit_timer.sv
// Loadable up-counter with clear and enable.
// Flags `expired` while the count sits at LIMIT-1.
module unit_timer
    import pong_pkg::*;
#(
    parameter  int LIMIT = 4096,
    localparam int WIDTH = safe_clog2(LIMIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // NOTE: the hold value is assigned first so every path defines count_d and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with <= so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/frame_scheduler.sv
// Runs each game-logic unit once per (divided) frame during vertical blanking,
// using a go/done handshake with a per-unit timeout and a sticky overrun flag.
module frame_scheduler
    import pong_pkg::*;
#(
    parameter  int N_UNITS   = 4,
    parameter  int TIMEOUT   = 4096,
    parameter  int FRAME_DIV = 1,
    localparam int IDX_W     = safe_clog2(N_UNITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   enable,
    input  logic [N_UNITS-1:0]     done,
    input  logic                   clr_overrun,
    output logic [N_UNITS-1:0]     go,
    output logic                   busy,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun,
    output logic [IDX_W-1:0]       fault_unit
);

    localparam int               DIV_W    = safe_clog2(FRAME_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UNITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    sched_state_t           state_d, state_q;
    logic [IDX_W-1:0]       idx_d, idx_q;
    logic [DIV_W-1:0]       div_d, div_q;
    logic [N_UNITS-1:0]     go_d, go_q;
    logic                   busy_d, busy_q;
    logic                   tick_d, tick_q;
    logic [FRAME_CNT_W-1:0] cnt_d, cnt_q;
    logic                   overrun_d, overrun_q;
    logic [IDX_W-1:0]       fault_d, fault_q;
    logic                   vsync_q;
    logic                   fall;
    logic                   overrun_set;
    logic                   timer_expired;

    assign fall = vsync_q & ~vsync;

    // The timer is held at zero outside GRANT, so each grant starts counting from 0.
    unit_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q != GRANT),
        .en       (state_q == GRANT),
        .load     (1'b0),
        .load_val ('0),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        tick_d      = 1'b0;
        overrun_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall && enable) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        cnt_d   = cnt_q + 1'b1;
                        idx_d   = '0;
                        tick_d  = 1'b1;
                        state_d = GRANT;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            GRANT: begin
                // A frame arriving mid-sequence is dropped, never queued.
                overrun_set = fall;
                if (done[idx_q]) begin
                    state_d = GAP;
                end else if (timer_expired) begin
                    overrun_set = 1'b1;
                    fault_d     = idx_q;
                    state_d     = GAP;
                end
            end
            GAP: begin
                overrun_set = fall;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        // Outputs are decoded from the next state so they are registered alongside it.
        go_d = '0;
        if (state_d == GRANT) begin
            go_d[idx_d] = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q   <= 1'b1;
            state_q   <= IDLE;
            idx_q     <= '0;
            div_q     <= '0;
            go_q      <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            fault_q   <= '0;
        end else begin
            vsync_q   <= vsync;
            state_q   <= state_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            go_q      <= go_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            fault_q   <= fault_d;
        end
    end

    assign go         = go_q;
    assign busy       = busy_q;
    assign frame_tick = tick_q;
    assign frame_cnt  = cnt_q;
    assign overrun    = overrun_q;
    assign fault_unit = fault_q;

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences per-frame game-logic updates (ball, paddles, collision, score) into the vertical blanking interval of the VGA timing generator. Detects the falling edge of the active-low `vsync`, optionally divides the frame rate, then grants each of `N_UNITS` update units a turn in fixed order through a go/done handshake. Sits between the VGA controller and the game-logic units. Flags overruns so that the renderer never samples half-updated game state.

## Interface
- `N_UNITS`, 4: number of sequenced update units; unit 0 runs first.
- `TIMEOUT`, 4096: maximum cycles a unit may hold `go` before it is abandoned.
- `FRAME_DIV`, 1: run one sequence every `FRAME_DIV` vsync falling edges (≥1).

Ports:
- `clk` in 1: pixel clock, same as the VGA controller.
- `reset` in 1: asynchronous, active-high.
- `vsync` in 1: active-low vertical sync from the VGA controller.
- `enable` in 1: when low, new frames are not started.
- `done` in N_UNITS: per-unit completion. Only the bit of the unit currently granted is honoured.
- `clr_overrun` in 1: synchronous clear of `overrun`.
- `go` out N_UNITS: one-hot or zero. The bit is held high while that unit is granted.
- `busy` out 1: a sequence is in progress.
- `frame_tick` out 1: one-cycle pulse at the start of each sequence.
- `frame_cnt` out 16: number of sequences started; wraps from 0xFFFF to 0.
- `overrun` out 1: sticky error flag.
- `fault_unit` out $clog2(N_UNITS): index of the unit that most recently timed out.

## Operation
- Reset values: all outputs 0; internal `vsync_q` = 1; divider = 0; state IDLE.
- Edge detect: `fall = vsync_q & ~vsync`, with `vsync_q` registered every cycle.
- States:
  - IDLE → GRANT on `fall & enable` when the divider equals `FRAME_DIV-1`.
    - Divider is cleared, `frame_cnt` increments, index = 0.
    - Otherwise a fall with `enable` high only increments the divider.
    - A fall with `enable` low changes nothing.
  - GRANT: `go[idx]` high; timer counts from 0.
    - `done[idx]` sampled high → GAP.
    - Timer reaches `TIMEOUT-1` without done → `overrun` set, `fault_unit` = idx, → GAP.
  - GAP: all `go` low for exactly one cycle.
    - If idx = N_UNITS-1 → IDLE.
    - Else idx+1 → GRANT, with the timer cleared.
- `busy` = state ≠ IDLE.
- A fall while not IDLE is dropped:
  - `overrun` is set, `frame_cnt` is not incremented, and the divider is unchanged.
  - The frame is not queued.
- `enable` falling mid-sequence has no effect; the current sequence completes.
- `done` bits of non-granted units and `done` in GAP or IDLE are ignored.
- `overrun`:
  - Set by a timeout or a dropped frame.
  - Cleared by `clr_overrun`.
  - Set wins when both occur in the same cycle.
- Reset asserted mid-sequence: `go` drops immediately (asynchronously) and there is no completion handshake.

## Timing
- Fall detected in cycle E.
  - `frame_tick` and `go[0]` are high in cycle E+1.
  - `busy` goes high in cycle E+1.
- `done[i]` high in cycle D:
  - `go[i]` goes low in D+1.
  - `go[i+1]` goes high in D+2.
  - For the last unit, `busy` goes low in D+2.
- Done in the first grant cycle is legal. Minimum sequence length is 2·N_UNITS cycles.
- Timeout: with `go[i]` high from cycle G, it is forced low in cycle G+TIMEOUT. A `done` in cycle G+TIMEOUT-1 counts as completion, with no overrun.
- `frame_cnt` updates in E+1, together with `frame_tick`.

## Structure
- `pong_pkg` holds:
  - the `sched_state_t` enum {IDLE, GRANT, GAP};
  - the `FRAME_CNT_W = 16` constant, shared with the score and debug logic.
- One sub-module, `unit_timer`:
  - a loadable up-counter of width $clog2(TIMEOUT) with clear, enable and an `expired` output;
  - reusable for the ball-speed divider.
- Edge detection, the divider and the FSM are inline.

## Test plan
- **Normal sequence:** N_UNITS=4, FRAME_DIV=1, each unit returns `done` 3 cycles after `go`.
  - Expect `go` to step 0001→0000→0010→0000→0100→0000→1000→0000.
  - Expect `frame_cnt`=1 and `busy` high for 4·4+… cycles exactly per the Timing rules.
  - Expect `overrun`=0.
- **Timeout:** TIMEOUT=8, unit 2 never asserts `done`.
  - Expect `go[2]` high for exactly 8 cycles, `overrun`=1, `fault_unit`=2.
  - Expect unit 3 still granted and the sequence to complete.
- **Frame divider:** FRAME_DIV=3, 7 vsync falls.
  - Expect sequences on falls 3 and 6 only, and `frame_cnt`=2.
- **Dropped frame:** a second vsync fall while unit 1 is granted.
  - Expect `overrun`=1, `frame_cnt` unchanged, and no second `frame_tick` after the sequence ends.
  - Then `clr_overrun` in the same cycle as a new timeout → `overrun` stays 1.
- **Enable and reset:**
  - `enable`=0 during a fall → no `frame_tick`.
  - `enable` dropped mid-sequence → the sequence completes.
  - `reset` pulsed while `go`=0100 → `go`=0, `busy`=0, `frame_cnt`=0 immediately.
  - `frame_cnt` preloaded by running 65536 sequences wraps to 0.
